// File: rtl/sdram_user_port_responder.sv
// Stand-in for the SDRAM controller user port: level req / one-cycle ack.
// Small register array with programmable latency and init/refresh stalls.
module sdram_user_port_responder #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 128,
    parameter int DEPTH_LOG2  = 4,
    parameter int WRITE_LAT   = 4,
    parameter int READ_LAT    = 6,
    parameter int INIT_CYCLES = 16,
    parameter int REF_PERIOD  = 64,
    parameter int REF_CYCLES  = 4
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iwrite_req,
    input  logic [ADDR_W-1:0] iwrite_address,
    input  logic [DATA_W-1:0] iwrite_data,
    output logic              owrite_ack,
    input  logic              iread_req,
    input  logic [ADDR_W-1:0] iread_address,
    output logic [DATA_W-1:0] oread_data,
    output logic              oread_ack,
    output logic              oinit_done,
    output logic              obusy,
    output logic              oaddr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = 16;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] REF_LAST  = CW'(REF_PERIOD - 1);
    localparam logic [CW-1:0] RF_LAST   = CW'(REF_CYCLES - 1);
    localparam logic [CW-1:0] WLAT      = CW'(WRITE_LAT);
    localparam logic [CW-1:0] RLAT      = CW'(READ_LAT);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REFRESH,
        S_WRITE,
        S_READ,
        S_ACK_W,
        S_ACK_R,
        S_DROP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]         init_cnt;
    logic [CW-1:0]         ref_cnt;
    logic [CW-1:0]         stall_cnt;
    logic [CW-1:0]         lat_cnt;
    logic                  ref_pend;
    logic                  ref_exp;
    logic                  ref_due;
    logic                  acc_w;
    logic                  acc_r;
    logic                  acc_oor;
    logic [ADDR_W-1:0]     acc_addr;
    logic [DATA_W-1:0]     acc_data;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [DATA_W-1:0]     mem [DEPTH];

    function automatic logic oor(input logic [ADDR_W-1:0] a);
        return (a >> DEPTH_LOG2) != '0;
    endfunction

    assign ref_exp = (state != S_INIT) && (ref_cnt == REF_LAST);
    assign ref_due = ref_pend || ref_exp;
    assign acc_oor = oor(acc_addr);
    assign acc_idx = acc_addr[DEPTH_LOG2-1:0];

    // next-state decode; refresh beats any request seen in IDLE
    always_comb begin
        state_nx = state;
        acc_w    = 1'b0;
        acc_r    = 1'b0;
        unique case (state)
            S_INIT: begin
                if (init_cnt == INIT_LAST)
                    state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (ref_due) begin
                    state_nx = S_REFRESH;
                end else if (iwrite_req) begin
                    state_nx = S_WRITE;
                    acc_w    = 1'b1;
                end else if (iread_req) begin
                    state_nx = S_READ;
                    acc_r    = 1'b1;
                end
            end
            S_REFRESH: begin
                if (stall_cnt == RF_LAST)
                    state_nx = S_IDLE;
            end
            S_WRITE: begin
                if (lat_cnt == WLAT)
                    state_nx = S_ACK_W;
            end
            S_READ: begin
                if (lat_cnt == RLAT)
                    state_nx = S_ACK_R;
            end
            S_ACK_W,
            S_ACK_R: begin
                state_nx = S_DROP;
            end
            S_DROP: begin
                if (!iwrite_req && !iread_req)
                    state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_INIT;
            end
        endcase
    end

    // state register
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n)
            state <= S_INIT;
        else
            state <= state_nx;
    end

    // init, refresh, stall and latency counters
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            init_cnt  <= '0;
            ref_cnt   <= '0;
            ref_pend  <= 1'b0;
            stall_cnt <= '0;
            lat_cnt   <= '0;
        end else begin
            if (state == S_INIT)
                init_cnt <= init_cnt + ONE;
            if (state != S_INIT)
                ref_cnt <= ref_exp ? '0 : ref_cnt + ONE;
            if (state == S_IDLE && ref_due)
                ref_pend <= 1'b0;
            else if (ref_exp)
                ref_pend <= 1'b1;
            stall_cnt <= (state == S_REFRESH) ? stall_cnt + ONE : '0;
            if (state == S_WRITE || state == S_READ)
                lat_cnt <= lat_cnt + ONE;
            else
                lat_cnt <= ONE;
        end
    end

    // capture the accepted request and flag out-of-range accesses
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            acc_addr  <= '0;
            acc_data  <= '0;
            oaddr_err <= 1'b0;
        end else begin
            if (acc_w) begin
                acc_addr <= iwrite_address;
                acc_data <= iwrite_data;
            end else if (acc_r) begin
                acc_addr <= iread_address;
            end
            if ((acc_w && oor(iwrite_address)) ||
                (acc_r && oor(iread_address)))
                oaddr_err <= 1'b1;
        end
    end

    // storage array, written on the edge entering the write ack
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (state_nx == S_ACK_W && !acc_oor) begin
            mem[acc_idx] <= acc_data;
        end
    end

    // registered user-port outputs
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            owrite_ack <= 1'b0;
            oread_ack  <= 1'b0;
            oread_data <= '0;
            oinit_done <= 1'b0;
            obusy      <= 1'b0;
        end else begin
            owrite_ack <= (state_nx == S_ACK_W);
            oread_ack  <= (state_nx == S_ACK_R);
            oinit_done <= (state_nx != S_INIT);
            obusy      <= (state_nx != S_IDLE);
            if (state_nx == S_ACK_R)
                oread_data <= acc_oor ? '0 : mem[acc_idx];
        end
    end

endmodule

// File: tb/tb_sdram_user_port_responder.sv
// Bench for sdram_user_port_responder: timestamp model plus
// directed scenarios with literal expectations.
module tb_sdram_user_port_responder;

    localparam int AW = 22;
    localparam int DW = 128;
    localparam int WL = 4;
    localparam int RL = 6;
    localparam int IC = 16;
    localparam int RP = 64;
    localparam int RC = 4;

    logic          iclk = 1'b0;
    logic          ireset_n;
    logic          iwrite_req;
    logic [AW-1:0] iwrite_address;
    logic [DW-1:0] iwrite_data;
    logic          owrite_ack;
    logic          iread_req;
    logic [AW-1:0] iread_address;
    logic [DW-1:0] oread_data;
    logic          oread_ack;
    logic          oinit_done;
    logic          obusy;
    logic          oaddr_err;

    int checks = 0;
    int errors = 0;
    int wack_n = 0;
    int rack_n = 0;

    always #5 iclk = ~iclk;

    sdram_user_port_responder #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(4),
        .WRITE_LAT(WL), .READ_LAT(RL), .INIT_CYCLES(IC),
        .REF_PERIOD(RP), .REF_CYCLES(RC)
    ) dut (
        .iclk(iclk),
        .ireset_n(ireset_n),
        .iwrite_req(iwrite_req),
        .iwrite_address(iwrite_address),
        .iwrite_data(iwrite_data),
        .owrite_ack(owrite_ack),
        .iread_req(iread_req),
        .iread_address(iread_address),
        .oread_data(oread_data),
        .oread_ack(oread_ack),
        .oinit_done(oinit_done),
        .obusy(obusy),
        .oaddr_err(oaddr_err)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        chk(nm, DW'(act), DW'(exp));
    endtask

    // behavioural model: edges since reset release and event timestamps
    typedef enum {P_INIT, P_IDLE, P_STALL, P_ACC, P_DROP} phase_t;

    phase_t        ph = P_INIT;
    int            n = 0;
    int            stall_end = 0;
    int            ack_edge = 0;
    int            drop_from = 0;
    bit            pend = 1'b0;
    bit            m_refexp = 1'b0;
    bit            m_is_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_mem [16];
    logic          e_done = 1'b0;
    logic          e_busy = 1'b0;
    logic          e_wack = 1'b0;
    logic          e_rack = 1'b0;
    logic          e_err = 1'b0;
    logic [DW-1:0] e_rdata = '0;

    always @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            ph = P_INIT; n = 0; pend = 1'b0;
            e_done = 1'b0; e_busy = 1'b0; e_wack = 1'b0;
            e_rack = 1'b0; e_err = 1'b0; e_rdata = '0;
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
        end else begin
            n++;
            e_wack = 1'b0;
            e_rack = 1'b0;
            m_refexp = (n > IC) && (((n - IC) % RP) == 0);
            if (n == IC) begin
                ph = P_IDLE;
            end else if (n > IC) begin
                if (m_refexp && ph != P_IDLE) pend = 1'b1;
                case (ph)
                    P_IDLE: begin
                        if (m_refexp || pend) begin
                            pend = 1'b0;
                            ph = P_STALL;
                            stall_end = n + RC;
                        end else if (iwrite_req || iread_req) begin
                            m_is_wr = iwrite_req;
                            m_addr = iwrite_req ? iwrite_address : iread_address;
                            m_data = iwrite_data;
                            ack_edge = n + (iwrite_req ? WL : RL);
                            if (m_addr >= AW'(16)) e_err = 1'b1;
                            ph = P_ACC;
                        end
                    end
                    P_STALL: if (n == stall_end) ph = P_IDLE;
                    P_ACC: begin
                        if (n == ack_edge) begin
                            if (m_is_wr) begin
                                if (m_addr < AW'(16)) m_mem[m_addr[3:0]] = m_data;
                                e_wack = 1'b1;
                            end else begin
                                e_rdata = (m_addr < AW'(16)) ? m_mem[m_addr[3:0]] : '0;
                                e_rack = 1'b1;
                            end
                            ph = P_DROP;
                            drop_from = n + 2;
                        end
                    end
                    P_DROP: begin
                        if (n >= drop_from && !iwrite_req && !iread_req)
                            ph = P_IDLE;
                    end
                    default: ph = P_INIT;
                endcase
            end
            e_done = (n >= IC);
            e_busy = (ph != P_IDLE);
        end
    end

    // every cycle: DUT outputs against the model, mid-cycle
    always @(negedge iclk) begin
        chk("init_done", DW'(oinit_done), DW'(e_done));
        chk("busy", DW'(obusy), DW'(e_busy));
        chk("write_ack", DW'(owrite_ack), DW'(e_wack));
        chk("read_ack", DW'(oread_ack), DW'(e_rack));
        chk("read_data", oread_data, e_rdata);
        chk("addr_err", DW'(oaddr_err), DW'(e_err));
        chk("ack_excl", DW'(owrite_ack & oread_ack), '0);
        if (owrite_ack) wack_n++;
        if (oread_ack) rack_n++;
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic wait_ack(input bit rd, output int j);
        j = 0;
        do begin
            tick();
            j++;
        end while (!(rd ? oread_ack : owrite_ack) && j < 200);
        if (!(rd ? oread_ack : owrite_ack)) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack in %0d cycles, want ack", j);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (obusy && k < 200) begin
            tick();
            k++;
        end
        if (obusy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1, want 0");
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int j);
        iwrite_address = a;
        iwrite_data = d;
        iwrite_req = 1'b1;
        wait_ack(1'b0, j);
        iwrite_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int j);
        iread_address = a;
        iread_req = 1'b1;
        wait_ack(1'b1, j);
        iread_req = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int j;
        int k;
        int w0;
        int r0;
        ireset_n = 1'b1;
        iwrite_req = 1'b0;
        iread_req = 1'b0;
        iwrite_address = '0;
        iread_address = '0;
        iwrite_data = '0;
        #2 ireset_n = 1'b0;
        repeat (3) tick();
        chki("rst_busy0", obusy, 0);
        ireset_n = 1'b1;

        // 1: init length, no acks
        repeat (IC - 1) tick();
        chki("init_early", oinit_done, 0);
        tick();
        chki("init_exact", oinit_done, 1);
        chki("idle_after_init", obusy, 0);
        chki("no_acks_init", wack_n + rack_n, 0);

        // 2: write then read back
        do_write(22'd2, 128'h5A, j);
        chki("wr_lat", j, WL + 1);
        do_read(22'd2, j);
        chki("rd_lat", j, RL + 1);
        chk("rd_data_5a", oread_data, 128'h5A);

        // 3: simultaneous requests, write first
        r0 = rack_n;
        iwrite_address = 22'd1;
        iwrite_data = 128'h33;
        iread_address = 22'd1;
        iwrite_req = 1'b1;
        iread_req = 1'b1;
        wait_ack(1'b0, j);
        chki("both_wr_lat", j, WL + 1);
        chki("both_no_rd", oread_ack, 0);
        iwrite_req = 1'b0;
        iread_req = 1'b0;
        wait_idle();
        chki("both_rd_dropped", rack_n - r0, 0);
        do_read(22'd1, j);
        chk("rd_data_33", oread_data, 128'h33);

        // 4: request held after ack
        w0 = wack_n;
        iwrite_address = 22'd3;
        iwrite_data = 128'hABCD;
        iwrite_req = 1'b1;
        wait_ack(1'b0, j);
        for (int i = 0; i < 3; i++) begin
            tick();
            chki("hold_busy", obusy, 1);
            chki("hold_no_ack", owrite_ack, 0);
        end
        iwrite_req = 1'b0;
        tick();
        chki("drop_release", obusy, 0);
        chki("one_ack", wack_n - w0, 1);

        // 5: out-of-range write
        do_write(22'd0, 128'h1111, j);
        chki("err_clear", oaddr_err, 0);
        do_write(22'h20, 128'hFFFF, j);
        chki("oor_wr_lat", j, WL + 1);
        chki("oor_err_set", oaddr_err, 1);
        do_read(22'd0, j);
        chki("rd0_lat", j, RL + 1);
        chk("oor_no_alias", oread_data, 128'h1111);

        // 6: request during refresh, then reset mid-read
        k = 0;
        while (!obusy && k < 200) begin
            tick();
            k++;
        end
        chki("refresh_seen", obusy, 1);
        iread_address = 22'h20;
        iread_req = 1'b1;
        wait_ack(1'b1, j);
        chki("rf_lat", j, RC + RL + 1);
        chk("oor_rd_zero", oread_data, '0);
        iread_req = 1'b0;
        wait_idle();
        do_read(22'd3, j);
        chki("rd3_lat", j, RL + 1);
        chk("rd_data_abcd", oread_data, 128'hABCD);
        r0 = rack_n;
        w0 = wack_n;
        iread_address = 22'd2;
        iread_req = 1'b1;
        repeat (3) tick();
        chki("mid_read_busy", obusy, 1);
        ireset_n = 1'b0;
        iread_req = 1'b0;
        #1;
        chk("rst_rdata", oread_data, '0);
        chki("rst_done", oinit_done, 0);
        chki("rst_err", oaddr_err, 0);
        repeat (10) tick();
        ireset_n = 1'b1;
        tick();
        chki("reinit_busy", obusy, 1);
        repeat (IC - 1) tick();
        chki("reinit_done", oinit_done, 1);
        chki("no_ack_after_rst", (rack_n - r0) + (wack_n - w0), 0);
        do_read(22'd2, j);
        chki("post_rst_lat", j, RL + 1);
        chk("array_cleared", oread_data, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
